// File: rtl/serial_word_bridge_if.sv
// Handshake bundle between the UART, the serial word bridge and the command processor.
// The slave modport is the bridge's own view; master is the surrounding environment.
interface serial_word_bridge_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_error;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_in;
  logic        word_in_valid;
  logic        word_in_ready;
  logic [7:0]  tx_byte;
  logic        start_tx;
  logic        tx_ready;
  logic        clear_status;
  logic        rx_overrun;
  logic        rx_fault;
  logic        rx_timeout;

  modport slave (
    input  rx_byte, rx_valid, rx_error, word_ready, word_in, word_in_valid,
           tx_ready, clear_status,
    output word_out, word_valid, word_in_ready, tx_byte, start_tx,
           rx_overrun, rx_fault, rx_timeout
  );

  modport master (
    output rx_byte, rx_valid, rx_error, word_ready, word_in, word_in_valid,
           tx_ready, clear_status,
    input  word_out, word_valid, word_in_ready, tx_byte, start_tx,
           rx_overrun, rx_fault, rx_timeout
  );
endinterface

// File: rtl/serial_word_bridge.sv
// Byte/word adapter between the UART and the command processor: packs RX bytes into
// 32-bit words (MSB first, with inter-byte timeout) and unpacks TX words into bytes.
module serial_word_bridge #(
  parameter int BYTE_TIMEOUT = 200000,
  parameter int TIMEOUT_W    = 18
) (
  input logic                 clk,
  input logic                 rst,
  serial_word_bridge_if.slave bus
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(BYTE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} TxState;

  // ---------------- RX packer ----------------
  logic [1:0]           byteCount;
  logic [23:0]          shiftReg;
  logic [TIMEOUT_W-1:0] timeoutCnt;
  logic                 byteAccept;
  logic                 byteError;
  logic                 wordDone;
  logic                 wordTaken;
  logic                 loadWord;
  logic                 timeoutHit;

  assign byteAccept = bus.rx_valid & ~bus.rx_error;
  assign byteError  = bus.rx_valid & bus.rx_error;
  assign wordDone   = byteAccept & (byteCount == 2'd3);
  assign wordTaken  = bus.word_valid & bus.word_ready;
  assign loadWord   = wordDone & (~bus.word_valid | bus.word_ready);
  // An arriving byte always beats an expiring timeout.
  assign timeoutHit = (byteCount != 2'd0) & (timeoutCnt == TIMEOUT_LAST) & ~bus.rx_valid;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byteCount  <= 2'd0;
      timeoutCnt <= '0;
    end else begin
      if (byteError || timeoutHit) begin
        byteCount <= 2'd0;
      end else if (byteAccept) begin
        byteCount <= byteCount + 2'd1;
      end

      if (bus.rx_valid || timeoutHit || byteCount == 2'd0) begin
        timeoutCnt <= '0;
      end else begin
        timeoutCnt <= timeoutCnt + TIMEOUT_W'(1);
      end
    end
  end

  // NOTE: pure datapath with no reset; it is only read once three fresh bytes have been shifted in.
  always_ff @(posedge clk) begin
    if (byteAccept) begin
      shiftReg <= {shiftReg[15:0], bus.rx_byte};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.rx_overrun <= 1'b0;
      bus.rx_fault   <= 1'b0;
      bus.rx_timeout <= 1'b0;
    end else begin
      if (loadWord) begin
        bus.word_out   <= {shiftReg, bus.rx_byte};
        bus.word_valid <= 1'b1;
      end else if (wordTaken) begin
        bus.word_valid <= 1'b0;
      end

      bus.rx_timeout <= timeoutHit;

      // Sticky flags: a set event in the same cycle as clear_status wins.
      if (wordDone && !loadWord) begin
        bus.rx_overrun <= 1'b1;
      end else if (bus.clear_status) begin
        bus.rx_overrun <= 1'b0;
      end

      if (byteError) begin
        bus.rx_fault <= 1'b1;
      end else if (bus.clear_status) begin
        bus.rx_fault <= 1'b0;
      end
    end
  end

  // ---------------- TX unpacker ----------------
  TxState      txState;
  TxState      txNext;
  logic [31:0] txShift;
  logic [1:0]  byteIdx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState <= IDLE;
    end else begin
      txState <= txNext;
    end
  end

  // The current byte always sits in txShift[31:24], so tx_byte is stable for a whole byte slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txShift <= '0;
      byteIdx <= 2'd0;
    end else if (txState == IDLE && bus.word_in_valid) begin
      txShift <= bus.word_in;
      byteIdx <= 2'd0;
    end else if (txState == WAIT_DONE && bus.tx_ready && byteIdx != 2'd3) begin
      txShift <= {txShift[23:0], 8'h00};
      byteIdx <= byteIdx + 2'd1;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    txNext = txState;
    case (txState)
      IDLE:      if (bus.word_in_valid) txNext = SEND;
      SEND:      if (bus.tx_ready)      txNext = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_ready)     txNext = WAIT_DONE;
      WAIT_DONE: if (bus.tx_ready)      txNext = (byteIdx == 2'd3) ? IDLE : SEND;
      default:                          txNext = IDLE;
    endcase
  end

  always_comb begin
    bus.word_in_ready = 1'b0;
    bus.start_tx      = 1'b0;
    bus.tx_byte       = txShift[31:24];
    case (txState)
      IDLE:    bus.word_in_ready = 1'b1;
      SEND:    bus.start_tx      = bus.tx_ready;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_word_bridge.sv
// Self-checking bench for serial_word_bridge: table-driven RX words, hand-written corner
// sequences, and queue scoreboards for delivered words and transmitted bytes.
module tb_serial_word_bridge;

  localparam int T  = 16;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_word_bridge_if bus ();

  serial_word_bridge #(.BYTE_TIMEOUT(T), .TIMEOUT_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          gap;
    logic [31:0] expWord;
  } RxVec;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rxQ[$];
  logic [7:0]  txQ[$];
  int          startCount  = 0;
  int          timeoutSeen = 0;
  bit          prevStart   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic err);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    bus.rx_error = err;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap, input bit expectLoad);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(gap);
      if (i == 3 && expectLoad) rxQ.push_back(w);
      sendByte(w[31-8*i -: 8], 1'b0);
    end
  endtask

  task automatic waitRxDrain(input string name);
    for (int k = 0; k < 50 && rxQ.size() != 0; k++) step();
    check(name, rxQ.size(), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_word_out"},      bus.word_out,      32'd0);
    check({tag, "_word_valid"},    bus.word_valid,    32'd0);
    check({tag, "_word_in_ready"}, bus.word_in_ready, 32'd1);
    check({tag, "_tx_byte"},       bus.tx_byte,       32'd0);
    check({tag, "_start_tx"},      bus.start_tx,      32'd0);
    check({tag, "_rx_overrun"},    bus.rx_overrun,    32'd0);
    check({tag, "_rx_fault"},      bus.rx_fault,      32'd0);
    check({tag, "_rx_timeout"},    bus.rx_timeout,    32'd0);
  endtask

  // Scoreboard monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.word_valid && bus.word_ready) begin
      if (rxQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %h expected no word", bus.word_out);
      end else begin
        check("rx_word", bus.word_out, rxQ.pop_front());
      end
    end
    if (bus.rx_timeout) timeoutSeen++;
    if (bus.start_tx) begin
      startCount++;
      if (prevStart) begin
        total++;
        bad++;
        $display("FAIL start_tx_repeat: got two consecutive cycles expected one");
      end
      if (txQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected: got byte %h expected none", bus.tx_byte);
      end else begin
        check("tx_byte", bus.tx_byte, {24'd0, txQ.pop_front()});
      end
    end
    prevStart = bus.start_tx;
  end

  // UART transmitter model: busy for 10 cycles after each start request.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.start_tx === 1'b1) begin
        @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.tx_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  RxVec vecs[5];
  int   t0;
  int   s0;
  int   s1;

  initial begin
    vecs[0] = '{32'hDEADBEEF, 4,     32'hDEADBEEF};
    vecs[1] = '{32'h00000000, 0,     32'h00000000};
    vecs[2] = '{32'hFFFFFFFF, 1,     32'hFFFFFFFF};
    vecs[3] = '{32'h13579BDF, T - 1, 32'h13579BDF};
    vecs[4] = '{32'h80000001, 7,     32'h80000001};

    bus.rx_byte       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.rx_error      = 1'b0;
    bus.word_ready    = 1'b1;
    bus.word_in       = 32'd0;
    bus.word_in_valid = 1'b0;
    bus.clear_status  = 1'b0;

    #1 rst = 1'b0;
    #1 checkReset("por");
    idle(2);
    rst = 1'b1;
    idle(2);

    // Table-driven words; the T-1 gap lands a byte exactly on the timeout cycle.
    for (int v = 0; v < 5; v++) begin
      t0 = timeoutSeen;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) idle(vecs[v].gap);
        if (i == 3) begin
          check("vec_pre_valid", bus.word_valid, 32'd0);
          rxQ.push_back(vecs[v].expWord);
        end
        sendByte(vecs[v].data[31-8*i -: 8], 1'b0);
      end
      check("vec_valid_latency", bus.word_valid, 32'd1);
      check("vec_word_out", bus.word_out, vecs[v].expWord);
      step();
      check("vec_valid_one_cycle", bus.word_valid, 32'd0);
      check("vec_no_timeout", timeoutSeen - t0, 32'd0);
      check("vec_no_overrun", bus.rx_overrun, 32'd0);
      check("vec_no_fault", bus.rx_fault, 32'd0);
    end
    waitRxDrain("vec_drain");

    // Overrun with a stalled consumer, then clear_status.
    bus.word_ready = 1'b0;
    sendWord(32'h01020304, 1, 1'b1);
    sendWord(32'h05060708, 1, 1'b0);
    check("ovr_word_held", bus.word_out, 32'h01020304);
    check("ovr_valid", bus.word_valid, 32'd1);
    check("ovr_flag", bus.rx_overrun, 32'd1);
    bus.clear_status = 1'b1;
    step();
    bus.clear_status = 1'b0;
    check("ovr_cleared", bus.rx_overrun, 32'd0);
    check("ovr_word_kept", bus.word_out, 32'h01020304);
    bus.word_ready = 1'b1;
    waitRxDrain("ovr_drain");
    sendWord(32'h0A0B0C0D, 1, 1'b1);
    waitRxDrain("ovr_next_drain");

    // Completion in the same cycle the held word is consumed: load, no overrun.
    bus.word_ready = 1'b0;
    sendWord(32'hA1A2A3A4, 0, 1'b1);
    idle(2);
    sendByte(8'hB1, 1'b0);
    sendByte(8'hB2, 1'b0);
    sendByte(8'hB3, 1'b0);
    bus.word_ready = 1'b1;
    rxQ.push_back(32'hB1B2B3B4);
    sendByte(8'hB4, 1'b0);
    check("simul_valid", bus.word_valid, 32'd1);
    check("simul_word", bus.word_out, 32'hB1B2B3B4);
    check("simul_no_overrun", bus.rx_overrun, 32'd0);
    waitRxDrain("simul_drain");

    // Inter-byte timeout discards the partial word with a single pulse.
    t0 = timeoutSeen;
    sendByte(8'hAA, 1'b0);
    idle(1);
    sendByte(8'hBB, 1'b0);
    idle(T - 1);
    check("to_not_yet", bus.rx_timeout, 32'd0);
    step();
    check("to_pulse", bus.rx_timeout, 32'd1);
    step();
    check("to_pulse_end", bus.rx_timeout, 32'd0);
    idle(3);
    check("to_count", timeoutSeen - t0, 32'd1);
    check("to_no_word", bus.word_valid, 32'd0);
    sendWord(32'h11223344, 1, 1'b1);
    waitRxDrain("to_next_drain");

    // Framing error discards the partial word and sets rx_fault.
    sendByte(8'h10, 1'b0);
    sendByte(8'h99, 1'b1);
    check("fault_flag", bus.rx_fault, 32'd1);
    sendWord(32'h20304050, 0, 1'b1);
    waitRxDrain("fault_drain");
    bus.clear_status = 1'b1;
    step();
    bus.clear_status = 1'b0;
    check("fault_cleared", bus.rx_fault, 32'd0);

    // TX unpacking through the UART handshake.
    s0 = startCount;
    bus.word_in       = 32'hCAFEF00D;
    bus.word_in_valid = 1'b1;
    txQ.push_back(8'hCA);
    txQ.push_back(8'hFE);
    txQ.push_back(8'hF0);
    txQ.push_back(8'h0D);
    step();
    bus.word_in_valid = 1'b0;
    check("tx_busy", bus.word_in_ready, 32'd0);
    for (int k = 0; k < 300 && !bus.word_in_ready; k++) step();
    check("tx_done_ready", bus.word_in_ready, 32'd1);
    check("tx_done_uart_idle", bus.tx_ready, 32'd1);
    check("tx_start_count", startCount - s0, 32'd4);
    check("tx_queue_empty", txQ.size(), 32'd0);

    // Reset in the middle of both a transmit and a partial RX word.
    s0 = startCount;
    bus.word_in       = 32'h12345678;
    bus.word_in_valid = 1'b1;
    txQ.push_back(8'h12);
    txQ.push_back(8'h34);
    step();
    bus.word_in_valid = 1'b0;
    for (int k = 0; k < 100 && (startCount - s0) < 2; k++) step();
    check("rst_tx_two_bytes", startCount - s0, 32'd2);
    sendByte(8'h77, 1'b0);
    sendByte(8'h88, 1'b0);
    sendByte(8'h99, 1'b0);
    rst = 1'b0;
    #1 checkReset("mid_reset");
    idle(2);
    rst = 1'b1;
    s1 = startCount;
    idle(25);
    check("rst_tx_no_resume", startCount - s1, 32'd0);
    check("rst_tx_idle", bus.word_in_ready, 32'd1);
    sendWord(32'h5A6B7C8D, 2, 1'b1);
    waitRxDrain("rst_rx_fresh");

    check("final_rx_queue", rxQ.size(), 32'd0);
    check("final_tx_queue", txQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_word_bridge.md
Name: serial_word_bridge

Overview:
- Byte-to-word adapter between the RS232 UART and the serial command processor.
- RX path: packs incoming UART bytes into 32-bit words, MSB first, with an inter-byte timeout that drops stale partial words.
- TX path: unpacks 32-bit response words into four UART bytes, MSB first, using the UART start/ready handshake.
- Runs on the ungated system clock.

Parameters:
- BYTE_TIMEOUT, 200000, clk cycles allowed between bytes of one word before the partial word is discarded; must be ≥ 2.
- TIMEOUT_W, 18, width of the timeout counter; must hold BYTE_TIMEOUT-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_byte  in  8  received byte from UART
- rx_valid  in  1  one cycle per received byte; each high cycle is one byte
- rx_error  in  1  UART framing error, same-cycle qualifier for rx_valid
- word_out  out  32  assembled word
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out
- word_in  in  32  word to transmit
- word_in_valid  in  1  word_in offered
- word_in_ready  out  1  bridge can accept word_in
- tx_byte  out  8  byte to UART
- start_tx  out  1  one-cycle transmit request
- tx_ready  in  1  UART transmitter idle
- clear_status  in  1  clears sticky flags
- rx_overrun  out  1  sticky: a completed word was dropped
- rx_fault  out  1  sticky: framing error seen
- rx_timeout  out  1  one-cycle pulse: partial word discarded

Behaviour:
- Reset values (async on rst=0): word_out=0, word_valid=0, word_in_ready=1, tx_byte=0, start_tx=0, rx_overrun=0, rx_fault=0, rx_timeout=0. Byte count=0, timeout counter=0, TX FSM=IDLE. Reset mid-word or mid-transmit abandons all in-flight data; nothing resumes.

RX packer:
- 2-bit byte count plus 24-bit shift register; bytes arrive MSB first.
- On rx_valid & !rx_error with count<3: shift byte in, count+1.
- On the 4th byte: word = {shift, rx_byte}; count→0.
  - If the output register is free (word_valid=0), or is being consumed this cycle (word_valid & word_ready), load word_out and set word_valid=1 on the next edge. Latency from last rx_valid to word_valid is 1 cycle.
  - Otherwise drop the new word, keep the old word_out, set rx_overrun.
- word_valid & word_ready with no new word completing: word_valid→0 next cycle; word_out holds its value.
- rx_valid & rx_error: byte ignored, partial word discarded (count→0), rx_fault set.
- Timeout counter:
  - Cleared on every rx_valid.
  - Increments while count≠0; held at 0 while count=0.
  - When it reaches BYTE_TIMEOUT-1 with count≠0: count→0, counter→0, rx_timeout high for exactly 1 cycle.
  - If rx_valid arrives in that same cycle, the byte wins: no timeout, byte accepted.
- Partial bytes keep accumulating while word_valid is stalled; only completion can overrun.
- clear_status: rx_overrun, rx_fault→0. A set event in the same cycle wins.

TX unpacker FSM:
- IDLE
  - word_in_ready=1.
  - On word_in_valid: latch word_in, byte index=0, go to SEND. word_in_ready=0 from the next cycle.
- SEND
  - tx_byte = word[31-8*idx -: 8].
  - When tx_ready=1: start_tx=1 for 1 cycle, go to WAIT_BUSY. Otherwise wait with start_tx=0.
- WAIT_BUSY
  - Wait for tx_ready=0, then go to WAIT_DONE.
- WAIT_DONE
  - Wait for tx_ready=1.
  - If idx=3 go to IDLE; else idx+1 and go to SEND.
- tx_byte is stable from SEND entry through WAIT_DONE exit.
- start_tx is never high in two consecutive cycles.
- RX and TX paths are fully independent. Simultaneous RX completion and TX activity has no interaction.

Test Plan:
- Bytes 0xDE,0xAD,0xBE,0xEF, 5 cycles apart, word_ready=1 → word_out=0xDEADBEEF, word_valid high 1 cycle, exactly 1 cycle after the 4th rx_valid; no flags set.
- Hold word_ready=0; send 0x01020304, then 0x05060708 → word_out stays 0x01020304, rx_overrun=1. Pulse clear_status → rx_overrun=0. Next word with word_ready=1 delivers normally.
- Send 0xAA,0xBB, then idle BYTE_TIMEOUT cycles → rx_timeout pulses once, no word. Then 0x11,0x22,0x33,0x44 → word_out=0x11223344.
- Send 0x10, then a byte with rx_error=1, then 0x20,0x30,0x40,0x50 → rx_fault=1, word_out=0x20304050.
- word_in=0xCAFEF00D, UART model drops tx_ready for 10 cycles per byte → start_tx pulses 4 times with tx_byte CA,FE,F0,0D; word_in_ready returns to 1 after the 4th tx_ready rise.
- Assert rst after the 2nd TX byte and after 3 RX bytes → all outputs at reset values. After release, a fresh 4-byte RX sequence assembles correctly and TX idles.
